// File: rtl/pzcorebus_pkg.sv
// rtl/pzcorebus_pkg.sv - pzcorebus types, monitor error indices and command helpers
package pzcorebus_pkg;
    localparam int PZCOREBUS_ID_WIDTH          = 4;
    localparam int PZCOREBUS_ADDRESS_WIDTH     = 32;
    localparam int PZCOREBUS_LENGTH_WIDTH      = 8;
    localparam int PZCOREBUS_DATA_WIDTH        = 32;
    localparam int PZCOREBUS_BYTE_ENABLE_WIDTH = PZCOREBUS_DATA_WIDTH / 8;
    localparam int PZCOREBUS_MONITOR_ERROR_WIDTH = 7;

    typedef enum logic [1:0] {
        PZCOREBUS_CSR      = 2'd0,
        PZCOREBUS_MEMORY_L = 2'd1,
        PZCOREBUS_MEMORY_H = 2'd2
    } pzcorebus_profile;

    typedef struct packed {
        pzcorebus_profile profile;
    } pzcorebus_config;

    typedef enum logic [2:0] {
        PZCOREBUS_NULL_COMMAND      = 3'd0,
        PZCOREBUS_READ              = 3'd1,
        PZCOREBUS_WRITE             = 3'd2,
        PZCOREBUS_WRITE_NON_POSTED  = 3'd3,
        PZCOREBUS_BROADCAST         = 3'd4,
        PZCOREBUS_ATOMIC            = 3'd5,
        PZCOREBUS_ATOMIC_NON_POSTED = 3'd6,
        PZCOREBUS_MESSAGE           = 3'd7
    } pzcorebus_command_type;

    typedef struct packed {
        pzcorebus_command_type                command;
        logic [PZCOREBUS_ID_WIDTH-1:0]        id;
        logic [PZCOREBUS_ADDRESS_WIDTH-1:0]   address;
        logic [PZCOREBUS_LENGTH_WIDTH-1:0]    length;
    } pzcorebus_command;

    typedef struct packed {
        logic [PZCOREBUS_DATA_WIDTH-1:0]        data;
        logic [PZCOREBUS_BYTE_ENABLE_WIDTH-1:0] byte_enable;
        logic                                   last;
    } pzcorebus_write_data;

    typedef struct packed {
        logic [PZCOREBUS_ID_WIDTH-1:0]   id;
        logic                            error;
        logic [PZCOREBUS_DATA_WIDTH-1:0] data;
        logic [1:0]                      last;
    } pzcorebus_response;

    typedef enum logic [2:0] {
        PZCOREBUS_MCMD_STALL_ERROR  = 3'd0,
        PZCOREBUS_MDATA_STALL_ERROR = 3'd1,
        PZCOREBUS_SRESP_STALL_ERROR = 3'd2,
        PZCOREBUS_SRESP_LAST_ERROR  = 3'd3,
        PZCOREBUS_OVERFLOW_ERROR    = 3'd4,
        PZCOREBUS_UNDERFLOW_ERROR   = 3'd5,
        PZCOREBUS_TIMEOUT_ERROR     = 3'd6
    } pzcorebus_monitor_error;

    function automatic logic is_response_command(pzcorebus_command_type command);
        case (command)
            PZCOREBUS_READ, PZCOREBUS_WRITE_NON_POSTED, PZCOREBUS_ATOMIC_NON_POSTED: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_memory_profile(pzcorebus_config bus_config);
        return bus_config.profile != PZCOREBUS_CSR;
    endfunction

    function automatic logic is_memory_h_profile(pzcorebus_config bus_config);
        return bus_config.profile == PZCOREBUS_MEMORY_H;
    endfunction
endpackage

// File: rtl/pzcorebus_if.sv
// rtl/pzcorebus_if.sv - pzcorebus port signals with master, slave and passive monitor views
interface pzcorebus_if;
    import pzcorebus_pkg::*;

    logic                                   mcmd_valid;
    logic                                   scmd_accept;
    pzcorebus_command_type                  mcmd_command;
    logic [PZCOREBUS_ID_WIDTH-1:0]          mcmd_id;
    logic [PZCOREBUS_ADDRESS_WIDTH-1:0]     mcmd_address;
    logic [PZCOREBUS_LENGTH_WIDTH-1:0]      mcmd_length;

    logic                                   mdata_valid;
    logic                                   sdata_accept;
    logic [PZCOREBUS_DATA_WIDTH-1:0]        mdata;
    logic [PZCOREBUS_BYTE_ENABLE_WIDTH-1:0] mdata_byte_enable;
    logic                                   mdata_last;

    logic                                   sresp_valid;
    logic                                   mresp_accept;
    logic [PZCOREBUS_ID_WIDTH-1:0]          sresp_id;
    logic                                   sresp_error;
    logic [PZCOREBUS_DATA_WIDTH-1:0]        sresp_data;
    logic [1:0]                             sresp_last;

    function automatic pzcorebus_command get_command();
        return '{command: mcmd_command, id: mcmd_id, address: mcmd_address, length: mcmd_length};
    endfunction

    function automatic pzcorebus_write_data get_write_data();
        return '{data: mdata, byte_enable: mdata_byte_enable, last: mdata_last};
    endfunction

    function automatic pzcorebus_response get_response();
        return '{id: sresp_id, error: sresp_error, data: sresp_data, last: sresp_last};
    endfunction

    modport master (
        output mcmd_valid, mcmd_command, mcmd_id, mcmd_address, mcmd_length,
        input  scmd_accept,
        output mdata_valid, mdata, mdata_byte_enable, mdata_last,
        input  sdata_accept,
        input  sresp_valid, sresp_id, sresp_error, sresp_data, sresp_last,
        output mresp_accept
    );

    modport slave (
        input  mcmd_valid, mcmd_command, mcmd_id, mcmd_address, mcmd_length,
        output scmd_accept,
        input  mdata_valid, mdata, mdata_byte_enable, mdata_last,
        output sdata_accept,
        output sresp_valid, sresp_id, sresp_error, sresp_data, sresp_last,
        input  mresp_accept
    );

    modport monitor (
        input  mcmd_valid, scmd_accept, mcmd_command, mcmd_id, mcmd_address, mcmd_length,
        input  mdata_valid, sdata_accept, mdata, mdata_byte_enable, mdata_last,
        input  sresp_valid, mresp_accept, sresp_id, sresp_error, sresp_data, sresp_last,
        import get_command, import get_write_data, import get_response
    );
endinterface

// File: rtl/pzcorebus_stall_checker.sv
// rtl/pzcorebus_stall_checker.sv - flags a channel whose payload moves or drops while stalled
module pzcorebus_stall_checker #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic             i_accept,
    input  logic [WIDTH-1:0] i_payload,
    output logic             o_violation
);
    logic             stalled_q;
    logic [WIDTH-1:0] payload_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stalled_q <= 1'b0;
            payload_q <= '0;
        end else begin
            stalled_q <= i_valid && !i_accept;
            payload_q <= i_payload;
        end
    end

    assign o_violation = stalled_q && (!i_valid || (i_payload != payload_q));
endmodule

// File: rtl/pzcorebus_protocol_monitor.sv
// rtl/pzcorebus_protocol_monitor.sv - passive pzcorebus checker with sticky flags and counters
// Optional concurrent assertions per error bit: PZCOREBUS_PROTOCOL_MONITOR_SVA_EN
module pzcorebus_protocol_monitor
    import pzcorebus_pkg::*;
#(
    parameter pzcorebus_config BUS_CONFIG      = '0,
    parameter int              MAX_OUTSTANDING = 16,
    parameter int              TIMEOUT_CYCLES  = 1024
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    pzcorebus_if.monitor                         bus_if,
    input  logic                                 i_clear_error,
    output logic [PZCOREBUS_MONITOR_ERROR_WIDTH-1:0] o_error,
    output logic                                 o_error_pulse,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] o_outstanding
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_COUNT = CNT_W'(MAX_OUTSTANDING);

    pzcorebus_command  mcmd;
    pzcorebus_response sresp;
    logic              mcmd_violation;
    logic              mdata_violation;
    logic              sresp_violation;
    logic              last_violation;
    logic              timeout_event;
    logic              overflow_event;
    logic              underflow_event;
    logic              command_accept;
    logic              final_response;

    logic [CNT_W-1:0]  count_q, count_d;
    logic [PZCOREBUS_MONITOR_ERROR_WIDTH-1:0] error_q, error_d, error_event;
    logic              pulse_q, pulse_d;

    always_comb begin
        mcmd  = bus_if.get_command();
        sresp = bus_if.get_response();
    end

    pzcorebus_stall_checker #(.WIDTH($bits(pzcorebus_command))) u_mcmd_check (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_valid(bus_if.mcmd_valid), .i_accept(bus_if.scmd_accept),
        .i_payload(mcmd), .o_violation(mcmd_violation)
    );

    pzcorebus_stall_checker #(.WIDTH($bits(pzcorebus_response))) u_sresp_check (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_valid(bus_if.sresp_valid), .i_accept(bus_if.mresp_accept),
        .i_payload(sresp), .o_violation(sresp_violation)
    );

    if (is_memory_profile(BUS_CONFIG)) begin : g_mdata_check
        pzcorebus_write_data mdata, mdata_masked;
        // Disabled byte lanes carry no meaning, so a master may change them freely.
        always_comb begin
            mdata        = bus_if.get_write_data();
            mdata_masked = mdata;
            for (int i = 0; i < PZCOREBUS_BYTE_ENABLE_WIDTH; i++) begin
                if (!mdata.byte_enable[i]) mdata_masked.data[8*i+:8] = 8'h00;
            end
        end
        pzcorebus_stall_checker #(.WIDTH($bits(pzcorebus_write_data))) u_mdata_check (
            .i_clk(i_clk), .i_rst(i_rst),
            .i_valid(bus_if.mdata_valid), .i_accept(bus_if.sdata_accept),
            .i_payload(mdata_masked), .o_violation(mdata_violation)
        );
    end else begin : g_no_mdata_check
        assign mdata_violation = 1'b0;
    end

    if (is_memory_h_profile(BUS_CONFIG)) begin : g_last_check
        assign last_violation = bus_if.sresp_valid && (sresp.last == 2'b01);
    end else begin : g_no_last_check
        assign last_violation = 1'b0;
    end

    assign command_accept = bus_if.mcmd_valid && bus_if.scmd_accept && is_response_command(mcmd.command);
    assign final_response = bus_if.sresp_valid && bus_if.mresp_accept && sresp.last[0];

    always_comb begin
        count_d         = count_q;
        overflow_event  = 1'b0;
        underflow_event = 1'b0;
        case ({command_accept, final_response})
            2'b10: begin
                if (count_q == MAX_COUNT) overflow_event = 1'b1;
                else                      count_d = count_q + CNT_W'(1);
            end
            2'b01: begin
                if (count_q == '0) underflow_event = 1'b1;
                else               count_d = count_q - CNT_W'(1);
            end
            2'b11: begin
                // Orphan response still lets the simultaneous command be counted.
                if (count_q == '0) begin
                    underflow_event = 1'b1;
                    count_d         = CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    if (TIMEOUT_CYCLES > 0) begin : g_watchdog
        localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
        localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
        logic [WD_W-1:0] wd_q, wd_d;
        logic            wd_expired_q;

        always_comb begin
            wd_d = wd_q;
            if ((count_q == '0) || (bus_if.sresp_valid && bus_if.mresp_accept)) wd_d = '0;
            else if (wd_q != WD_LIMIT)                                           wd_d = wd_q + WD_W'(1);
        end

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                wd_q         <= '0;
                wd_expired_q <= 1'b0;
            end else begin
                wd_q         <= wd_d;
                wd_expired_q <= (wd_q == WD_LIMIT);
            end
        end

        // One event per expiry; the watchdog parks at the limit until cleared.
        assign timeout_event = (wd_q == WD_LIMIT) && !wd_expired_q;
    end else begin : g_no_watchdog
        assign timeout_event = 1'b0;
    end

    always_comb begin
        error_event = '0;
        error_event[PZCOREBUS_MCMD_STALL_ERROR]  = mcmd_violation;
        error_event[PZCOREBUS_MDATA_STALL_ERROR] = mdata_violation;
        error_event[PZCOREBUS_SRESP_STALL_ERROR] = sresp_violation;
        error_event[PZCOREBUS_SRESP_LAST_ERROR]  = last_violation;
        error_event[PZCOREBUS_OVERFLOW_ERROR]    = overflow_event;
        error_event[PZCOREBUS_UNDERFLOW_ERROR]   = underflow_event;
        error_event[PZCOREBUS_TIMEOUT_ERROR]     = timeout_event;
        error_d = (i_clear_error ? '0 : error_q) | error_event;
        pulse_d = |(error_d & ~error_q);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count_q <= '0;
            error_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            count_q <= count_d;
            error_q <= error_d;
            pulse_q <= pulse_d;
        end
    end

    assign o_error       = error_q;
    assign o_error_pulse = pulse_q;
    assign o_outstanding = count_q;

`ifdef PZCOREBUS_PROTOCOL_MONITOR_SVA_EN
    for (genvar i = 0; i < PZCOREBUS_MONITOR_ERROR_WIDTH; i++) begin : g_sva
        assert property (@(posedge i_clk) disable iff (i_rst) !error_event[i])
            else $fatal(1, "pzcorebus protocol violation, error bit %0d", i);
    end
`endif
endmodule

// File: tb/tb_pzcorebus_protocol_monitor.sv
// tb/tb_pzcorebus_protocol_monitor.sv - directed bench with a cycle model of the monitor rules
module tb_pzcorebus_protocol_monitor;
    import pzcorebus_pkg::*;

    localparam pzcorebus_config CFG = '{profile: PZCOREBUS_MEMORY_H};
    localparam int MAX_OUT = 2;
    localparam int TIMEOUT = 8;
    localparam bit IS_MEM  = 1'b1;
    localparam bit IS_MEMH = 1'b1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear_error = 1'b0;
    logic [6:0] dut_error;
    logic       dut_pulse;
    logic [$clog2(MAX_OUT+1)-1:0] dut_outstanding;

    int checks = 0;
    int errors = 0;

    pzcorebus_if bus ();

    pzcorebus_protocol_monitor #(
        .BUS_CONFIG(CFG), .MAX_OUTSTANDING(MAX_OUT), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .i_clk(clk), .i_rst(rst), .bus_if(bus), .i_clear_error(clear_error),
        .o_error(dut_error), .o_error_pulse(dut_pulse), .o_outstanding(dut_outstanding)
    );

    always #5 clk = ~clk;

    // Reference model: state as plain integers and snapshots of the raw bus fields.
    logic [6:0]  m_err;
    logic        m_pulse;
    int          m_count;
    int          m_quiet;
    logic        m_cmd_stalled, m_data_stalled, m_resp_stalled;
    logic [46:0] m_cmd_prev;
    logic [31:0] m_data_prev;
    logic [38:0] m_resp_prev;

    logic [46:0] cur_cmd;
    logic [31:0] cur_data;
    logic [38:0] cur_resp;
    logic [6:0]  ev;
    logic [6:0]  next_err;
    logic        rsp_cmd, beat, fin;
    int          next_count, next_quiet;

    always_comb begin
        cur_cmd  = {bus.mcmd_command, bus.mcmd_id, bus.mcmd_address, bus.mcmd_length};
        cur_data = 32'h0;
        for (int b = 0; b < 4; b++)
            if (bus.mdata_byte_enable[b]) cur_data[8*b+:8] = bus.mdata[8*b+:8];
        cur_resp = {bus.sresp_id, bus.sresp_error, bus.sresp_data, bus.sresp_last};
        rsp_cmd  = bus.mcmd_valid && bus.scmd_accept &&
                   (bus.mcmd_command inside {PZCOREBUS_READ, PZCOREBUS_WRITE_NON_POSTED,
                                             PZCOREBUS_ATOMIC_NON_POSTED});
        beat = bus.sresp_valid && bus.mresp_accept;
        fin  = beat && bus.sresp_last[0];
        ev = 7'h0;
        if (m_cmd_stalled && (!bus.mcmd_valid || cur_cmd != m_cmd_prev)) ev[0] = 1'b1;
        if (IS_MEM && m_data_stalled && (!bus.mdata_valid || cur_data != m_data_prev)) ev[1] = 1'b1;
        if (m_resp_stalled && (!bus.sresp_valid || cur_resp != m_resp_prev)) ev[2] = 1'b1;
        if (IS_MEMH && bus.sresp_valid && bus.sresp_last == 2'b01) ev[3] = 1'b1;
        if (TIMEOUT > 0 && m_quiet == TIMEOUT) ev[6] = 1'b1;
        next_quiet = (m_count > 0 && !beat) ? m_quiet + 1 : 0;
        next_count = m_count;
        if (fin && m_count == 0) begin
            ev[5] = 1'b1;
            next_count = rsp_cmd ? 1 : 0;
        end else if (rsp_cmd && !fin && m_count == MAX_OUT) begin
            ev[4] = 1'b1;
        end else begin
            next_count = m_count + (rsp_cmd ? 1 : 0) - (fin ? 1 : 0);
        end
        next_err = (clear_error ? 7'h0 : m_err) | ev;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_err <= '0; m_pulse <= 1'b0; m_count <= 0; m_quiet <= 0;
            m_cmd_stalled <= 1'b0; m_data_stalled <= 1'b0; m_resp_stalled <= 1'b0;
            m_cmd_prev <= '0; m_data_prev <= '0; m_resp_prev <= '0;
        end else begin
            m_err          <= next_err;
            m_pulse        <= |(next_err & ~m_err);
            m_count        <= next_count;
            m_quiet        <= next_quiet;
            m_cmd_stalled  <= bus.mcmd_valid && !bus.scmd_accept;
            m_data_stalled <= bus.mdata_valid && !bus.sdata_accept;
            m_resp_stalled <= bus.sresp_valid && !bus.mresp_accept;
            m_cmd_prev     <= cur_cmd;
            m_data_prev    <= cur_data;
            m_resp_prev    <= cur_resp;
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model_error", int'(dut_error), int'(m_err));
        check("model_pulse", int'(dut_pulse), int'(m_pulse));
        check("model_outstanding", int'(dut_outstanding), m_count);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.mcmd_valid = 1'b0; bus.scmd_accept = 1'b0; bus.mcmd_command = PZCOREBUS_NULL_COMMAND;
        bus.mcmd_id = '0; bus.mcmd_address = '0; bus.mcmd_length = '0;
        bus.mdata_valid = 1'b0; bus.sdata_accept = 1'b0; bus.mdata = '0;
        bus.mdata_byte_enable = '0; bus.mdata_last = 1'b0;
        bus.sresp_valid = 1'b0; bus.mresp_accept = 1'b0; bus.sresp_id = '0;
        bus.sresp_error = 1'b0; bus.sresp_data = '0; bus.sresp_last = 2'b00;
    endtask

    task automatic command(input pzcorebus_command_type t, input logic [31:0] addr, input logic acc);
        bus.mcmd_valid = 1'b1; bus.mcmd_command = t; bus.mcmd_address = addr; bus.scmd_accept = acc;
    endtask

    task automatic response(input logic [1:0] last, input logic acc);
        bus.sresp_valid = 1'b1; bus.sresp_last = last; bus.mresp_accept = acc; bus.sresp_data = 32'hC0DE;
    endtask

    task automatic clear();
        idle();
        clear_error = 1'b1;
        tick();
        clear_error = 1'b0;
        check("cleared", int'(dut_error), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout errors=%0d", errors);
        $fatal(1, "bench did not finish");
    end

    initial begin
        idle();
        rst = 1'b1;
        tick(); tick();
        check("reset_error", int'(dut_error), 0);
        check("reset_pulse", int'(dut_pulse), 0);
        check("reset_outstanding", int'(dut_outstanding), 0);
        rst = 1'b0;
        tick();

        // mcmd stalled three cycles, address moves in the third
        command(PZCOREBUS_WRITE, 32'h1000, 1'b0); tick();
        tick();
        bus.mcmd_address = 32'h2000; tick();
        check("mcmd_stall_error", int'(dut_error), 7'b0000001);
        check("mcmd_stall_pulse", int'(dut_pulse), 1);
        bus.scmd_accept = 1'b1; tick();
        check("mcmd_single_pulse", int'(dut_pulse), 0);
        clear();

        // mdata: disabled lane may move, enabled lane may not
        bus.mdata_valid = 1'b1; bus.mdata = 32'h11223344; bus.mdata_byte_enable = 4'b0011; tick();
        bus.mdata = 32'hAA223344; tick();
        check("mdata_masked_change", int'(dut_error), 0);
        bus.mdata = 32'hAA2233FF; tick();
        check("mdata_stall_error", int'(dut_error), 7'b0000010);
        bus.sdata_accept = 1'b1; tick();
        clear();

        // overflow at MAX_OUTSTANDING = 2
        command(PZCOREBUS_READ, 32'h0, 1'b1); tick(); tick(); tick();
        check("overflow_count", int'(dut_outstanding), 2);
        check("overflow_error", int'(dut_error), 7'b0010000);
        response(2'b11, 1'b1); tick();
        check("cmd_and_final_count", int'(dut_outstanding), 2);
        bus.mcmd_valid = 1'b0; tick(); tick();
        check("drained_count", int'(dut_outstanding), 0);
        clear();

        // underflow
        response(2'b11, 1'b1); tick();
        check("underflow_error", int'(dut_error), 7'b0100000);
        check("underflow_count", int'(dut_outstanding), 0);
        clear();

        // timeout after 8 quiet cycles
        command(PZCOREBUS_READ, 32'h40, 1'b1); tick();
        idle();
        repeat (8) tick();
        check("timeout_not_yet", int'(dut_error[6]), 0);
        tick();
        check("timeout_error", int'(dut_error), 7'b1000000);
        response(2'b11, 1'b1); tick();
        clear();

        // non-final beats every 5 cycles keep the watchdog quiet
        command(PZCOREBUS_READ, 32'h80, 1'b1); tick();
        for (int c = 1; c <= 20; c++) begin
            idle();
            if (c % 5 == 0) response(2'b00, 1'b1);
            tick();
        end
        check("no_timeout_with_beats", int'(dut_error), 0);
        response(2'b11, 1'b1); tick();
        idle(); tick();
        check("beats_drained", int'(dut_outstanding), 0);

        // memory_h last encoding, then reset mid-burst
        command(PZCOREBUS_READ, 32'hC0, 1'b1); tick();
        idle();
        response(2'b01, 1'b1); tick();
        check("last_error", int'(dut_error), 7'b0001000);
        check("last_count", int'(dut_outstanding), 0);
        idle();
        command(PZCOREBUS_READ, 32'hE0, 1'b1); tick();
        idle();
        response(2'b00, 1'b0); tick(); tick();
        rst = 1'b1;
        #1;
        check("async_reset_error", int'(dut_error), 0);
        check("async_reset_pulse", int'(dut_pulse), 0);
        check("async_reset_count", int'(dut_outstanding), 0);
        idle();
        tick();
        rst = 1'b0;
        response(2'b11, 1'b1); tick();
        check("post_reset_underflow", int'(dut_error), 7'b0100000);
        idle(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
